// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state/trigger-mode types and the edge-trigger decision helper.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT
    } cap_state_t;

    typedef enum logic [1:0] {
        TRIG_IMM,
        TRIG_RISE,
        TRIG_FALL,
        TRIG_BOTH
    } trig_mode_t;

    // prev_ge/cur_ge are the previous/current strobed samples compared (>=) against the level
    function automatic logic trig_hit(input trig_mode_t mode, input logic prev_ge,
                                      input logic cur_ge);
        logic rise;
        logic fall;
        rise = !prev_ge && cur_ge;
        fall = prev_ge && !cur_ge;
        case (mode)
            TRIG_IMM:  trig_hit = 1'b1;
            TRIG_RISE: trig_hit = rise;
            TRIG_FALL: trig_hit = fall;
            default:   trig_hit = rise || fall;
        endcase
    endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// capture_ram: simple dual-port sample buffer, one write port and one registered read port.
module capture_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: decimated, triggered block capture of the ADC bus with valid/ready readout.
// Build macro ADC_CAPTURE_MINMAX_EN adds blk_min/blk_max statistics of the stored block.
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int ADDR_WIDTH  = 10,
    parameter int DECIM_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  adc_data,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [1:0]             trig_mode,
    input  logic [DATA_WIDTH-1:0]  trig_level,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic [ADDR_WIDTH-1:0]  sample_count,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
`ifdef ADC_CAPTURE_MINMAX_EN
    ,
    output logic [DATA_WIDTH-1:0]  blk_min,
    output logic [DATA_WIDTH-1:0]  blk_max
`endif
);

    cap_state_t             state;
    trig_mode_t             mode_r;
    logic [DATA_WIDTH-1:0]  adc_q;
    logic [DATA_WIDTH-1:0]  level_r;
    logic [DECIM_WIDTH-1:0] decim_r;
    logic [DECIM_WIDTH-1:0] dcnt;
    logic [ADDR_WIDTH:0]    n_full;
    logic [ADDR_WIDTH:0]    wr_cnt;
    logic [ADDR_WIDTH:0]    rd_cnt;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [ADDR_WIDTH-1:0]  raddr;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   primed;
    logic                   prev_ge;
    logic                   q_vld;
    logic                   q_last;

    logic strobe;
    logic cur_ge;
    logic trig;
    logic we;
    logic re;
    logic out_adv;
    logic q_adv;
    logic final_hs;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            adc_q <= '0;
        else
            adc_q <= adc_data;
    end

    // Read pipeline: RAM output register (q) feeds the output register; each stage
    // advances when the stage after it is empty or being consumed, so no bubbles at ready=1.
    always_comb begin
        strobe   = 1'b0;
        cur_ge   = 1'b0;
        trig     = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        out_adv  = !out_valid || out_ready;
        q_adv    = !q_vld || out_adv;
        final_hs = out_valid && out_ready && out_last;
        if (!abort) begin
            strobe = ((state == ARMED) || (state == CAPTURE)) && (dcnt == '0);
            cur_ge = (adc_q >= level_r);
            trig   = strobe && (state == ARMED) &&
                     ((mode_r == TRIG_IMM) || (primed && trig_hit(mode_r, prev_ge, cur_ge)));
            we     = trig || (strobe && (state == CAPTURE));
            re     = (state == READOUT) && q_adv && (rd_cnt != n_full);
        end
    end

    capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (adc_q),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_r    <= TRIG_IMM;
            level_r   <= '0;
            decim_r   <= '0;
            dcnt      <= '0;
            n_full    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            waddr     <= '0;
            raddr     <= '0;
            primed    <= 1'b0;
            prev_ge   <= 1'b0;
            q_vld     <= 1'b0;
            q_last    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                q_vld     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            mode_r  <= trig_mode_t'(trig_mode);
                            level_r <= trig_level;
                            decim_r <= decim;
                            dcnt    <= decim;
                            n_full  <= (sample_count == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                            : {1'b0, sample_count};
                            primed  <= 1'b0;
                            prev_ge <= 1'b0;
                            waddr   <= '0;
                            wr_cnt  <= '0;
                            state   <= ARMED;
                        end
                    end
                    ARMED, CAPTURE: begin
                        if (strobe) begin
                            dcnt    <= decim_r;
                            primed  <= 1'b1;
                            prev_ge <= cur_ge;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                        if (we) begin
                            waddr  <= waddr + 1'b1;
                            wr_cnt <= wr_cnt + 1'b1;
                            if (wr_cnt + 1'b1 == n_full) begin
                                state  <= READOUT;
                                rd_cnt <= '0;
                                raddr  <= '0;
                            end else if (state == ARMED) begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    READOUT: begin
                        if (re) begin
                            raddr  <= raddr + 1'b1;
                            rd_cnt <= rd_cnt + 1'b1;
                            q_last <= (rd_cnt + 1'b1 == n_full);
                        end
                        if (q_adv)
                            q_vld <= re;
                        if (out_adv) begin
                            out_valid <= q_vld;
                            if (q_vld) begin
                                out_data <= rdata;
                                out_last <= q_last;
                            end
                        end
                        if (final_hs) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ADC_CAPTURE_MINMAX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_min <= '0;
            blk_max <= '0;
        end else if (we) begin
            if (state == ARMED) begin
                blk_min <= adc_q;
                blk_max <= adc_q;
            end else begin
                if (adc_q < blk_min)
                    blk_min <= adc_q;
                if (adc_q > blk_max)
                    blk_max <= adc_q;
            end
        end
    end
`endif

endmodule
